// File: rtl/inst_fetch_queue.sv
// Circular FIFO of {pc, instruction} pairs between fetch and decode.
// Valid/ready on both sides, flush on redirect, and a sticky overflow flag.
module inst_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [INST_W-1:0] in_inst,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d   [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              push_s;
    logic              pop_s;

    // Handshake status derives only from registered occupancy.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign push_s    = in_valid & in_ready & ~flush;
    assign pop_s     = out_valid & out_ready & ~flush;

    // Head read is gated so decode never sees stale storage when empty.
    always_comb begin
        if (out_valid) begin
            out_pc   = pc_mem_q[rd_ptr_q];
            out_inst = inst_mem_q[rd_ptr_q];
        end else begin
            out_pc   = {ADDR_W{1'b0}};
            out_inst = {INST_W{1'b0}};
        end
    end

    // Next-state: storage write, pointer advance, occupancy and overflow.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (in_valid & ~in_ready & ~flush);
        if (push_s) begin
            pc_mem_d[wr_ptr_q]   = in_pc;
            inst_mem_d[wr_ptr_q] = in_inst;
            wr_ptr_d             = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
        // Storage is deliberately left intact on a redirect.
        if (flush) begin
            rd_ptr_d = {PTR_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            count_d = count_d;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= {ADDR_W{1'b0}};
                inst_mem_q[i] <= {INST_W{1'b0}};
            end
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            pc_mem_q   <= pc_mem_d;
            inst_mem_q <= inst_mem_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed plus randomized bench for inst_fetch_queue, checked every cycle
// against a queue-based reference model.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_pc = 64'h0;
    logic [31:0] in_inst = 32'h0;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready = 1'b0;
    logic [2:0]  count;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    logic [95:0] model_q[$];
    logic        model_ovf = 1'b0;
    logic        model_known = 1'b0;
    logic [63:0] pc_gen = 64'h1000;

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [63:0] e_pc;
        logic [31:0] e_inst;
        e_pc = 64'h0;
        e_inst = 32'h0;
        if (model_q.size() != 0) begin
            e_pc = model_q[0][95:32];
            e_inst = model_q[0][31:0];
        end
        chk("count", {61'b0, count}, 64'(model_q.size()));
        chk("in_ready", {63'b0, in_ready}, {63'b0, (model_q.size() != DEPTH)});
        chk("out_valid", {63'b0, out_valid}, {63'b0, (model_q.size() != 0)});
        chk("out_pc", out_pc, e_pc);
        chk("out_inst", {32'b0, out_inst}, {32'b0, e_inst});
        chk("overflow", {63'b0, overflow}, {63'b0, model_ovf});
    endtask

    // Drive one cycle: inputs at negedge, check pre-edge outputs, advance model.
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [63:0] pc, input logic ordy);
        logic full;
        rst = r;
        flush = f;
        in_valid = v;
        in_pc = pc;
        in_inst = $urandom;
        out_ready = ordy;
        #1;
        if (model_known) check_all();
        if (r) begin
            model_q.delete();
            model_ovf = 1'b0;
            model_known = 1'b1;
        end else if (f) begin
            model_q.delete();
        end else begin
            full = (model_q.size() == DEPTH);
            if (v && full) model_ovf = 1'b1;
            if (ordy && model_q.size() != 0) void'(model_q.pop_front());
            if (v && !full) model_q.push_back({pc, in_inst});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset, then fill with 0x0..0xC while decode stalls
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 64'(i * 4), 1'b0);
        // Drain with pushes mid-way, including a pop attempt when empty
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h10, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h14, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        // Simultaneous push/pop at count 2
        cyc(1'b0, 1'b0, 1'b1, 64'h100, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h104, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b1, 64'(64'h108 + i * 4), 1'b1);
        // Flush at count 3 with concurrent traffic, then push 0x80
        cyc(1'b0, 1'b0, 1'b1, 64'h120, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 64'h124, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 64'h80, 1'b0);
        // Fill to full, present 0x40 while full, drain, then reset clears overflow
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 64'(64'h84 + i * 4), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h40, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h44, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0);
        // Reset mid-operation at count 2 with a push presented
        cyc(1'b0, 1'b0, 1'b1, 64'h200, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 64'h204, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 64'h208, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
        // Randomized traffic with unique PCs
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 60) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                pc_gen, ($urandom % 3) != 0);
            pc_gen = pc_gen + 64'h4;
        end
        #1;
        check_all();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
